// File: rtl/fetch_queue_unit.sv
// Fetch front-end: PC register, instruction-memory request and a DEPTH-entry
// instruction queue that decouples fetch from decode through a valid/ready handshake.
module fetch_queue_unit #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         imem_req,
    output logic [XLEN-1:0]              imem_addr,
    input  logic [XLEN-1:0]              imem_rdata,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [XLEN-1:0]              instrD,
    output logic [XLEN-1:0]              PCD,
    output logic [XLEN-1:0]              PCPlus4D,
    output logic [$clog2(DEPTH+1)-1:0]   q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    function automatic logic [XLEN-1:0] pcPlus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

    function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

    logic [XLEN-1:0] pcF;
    logic            reqVld_p1;
    logic [XLEN-1:0] reqPc_p1;
    logic [XLEN-1:0] instrMem [DEPTH];
    logic [XLEN-1:0] pcMem    [DEPTH];
    logic [PW-1:0]   wrPtr;
    logic [PW-1:0]   rdPtr;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic            pop;
    logic            push;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready & ~redirect_valid;
    assign push        = reqVld_p1 & ~redirect_valid;

    // Entries already queued plus the one still in flight, less the one leaving now.
    assign occupancy = {1'b0, count} + (CW+1)'(reqVld_p1) - (CW+1)'(pop);
    assign imem_req  = ~rst & ~redirect_valid & (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = pcF;
    assign q_count   = count;

    // Stage p0: PC register and request issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcF       <= RESET_PC;
            reqVld_p1 <= 1'b0;
        end else if (redirect_valid) begin
            pcF       <= alignPc(redirect_pc);
            reqVld_p1 <= 1'b0;
        end else begin
            reqVld_p1 <= imem_req;
            if (imem_req) begin
                pcF <= pcPlus4(pcF);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req) begin
            reqPc_p1 <= pcF;
        end
    end

    // Stage p1: response lands in the queue tail.
    always_ff @(posedge clk) begin
        if (push) begin
            instrMem[wrPtr] <= imem_rdata;
            pcMem[wrPtr]    <= reqPc_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset; an empty queue presents zeros instead of stale data.
    assign instrD   = instr_valid ? instrMem[rdPtr]         : '0;
    assign PCD      = instr_valid ? pcMem[rdPtr]            : '0;
    assign PCPlus4D = instr_valid ? pcPlus4(pcMem[rdPtr])   : '0;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: an address-derived instruction memory model
// and a queue of expected PCs that is consumed on every decode handshake.
module tb_fetch_queue_unit;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] MAGIC    = 32'hCAFE_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [2:0]  q_count;

    fetch_queue_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instrD         (instrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .q_count        (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers one cycle after the request with a word derived from the address.
    logic [31:0] memAddr;
    always @(posedge clk) begin
        if (imem_req) memAddr <= imem_addr;
    end
    assign imem_rdata = memAddr ^ MAGIC;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] expQ[$];

    logic        sampValid;
    logic        sampReq;
    logic [31:0] sampAddr;
    logic [31:0] sampCount;
    logic [31:0] sampPcd;
    logic [31:0] sampP4;
    logic [31:0] sampInstr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic loadExp(input logic [31:0] startPc);
        expQ.delete();
        for (int i = 0; i < 64; i++) expQ.push_back(startPc + 32'(4 * i));
    endtask

    task automatic monitor();
        logic [31:0] expPc;
        if (instr_valid && instr_ready && !redirect_valid) begin
            checks++;
            assert (expQ.size() != 0) else begin
                failures++;
                $error("FAIL delivery observed=0x%08h expected=none", PCD);
            end
            if (expQ.size() != 0) begin
                expPc = expQ.pop_front();
                check("PCD", PCD, expPc);
                check("PCPlus4D", PCPlus4D, expPc + 32'd4);
                check("instrD", instrD, expPc ^ MAGIC);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sampValid = instr_valid;
        sampReq   = imem_req;
        sampAddr  = imem_addr;
        sampCount = 32'(q_count);
        sampPcd   = PCD;
        sampP4    = PCPlus4D;
        sampInstr = instrD;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic redirectTo(input logic [31:0] target, input logic [31:0] aligned);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        loadExp(aligned);
        tick();
        check("redir_no_req", 32'(sampReq), 32'd0);
        redirect_valid = 1'b0;
        tick();
        check("redir_t1_count", sampCount, 32'd0);
        check("redir_t1_valid", 32'(sampValid), 32'd0);
        check("redir_t1_req", 32'(sampReq), 32'd1);
        check("redir_t1_addr", sampAddr, aligned);
        tick();
        check("redir_t2_valid", 32'(sampValid), 32'd0);
        tick();
        check("redir_t3_valid", 32'(sampValid), 32'd1);
        check("redir_t3_pcd", sampPcd, aligned);
    endtask

    initial begin
        int lat;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        expQ.delete();

        tick();
        check("rst_valid", 32'(sampValid), 32'd0);
        check("rst_count", sampCount, 32'd0);
        check("rst_req", 32'(sampReq), 32'd0);
        check("rst_addr", sampAddr, RESET_PC);
        check("rst_pcd", sampPcd, 32'd0);
        check("rst_pcplus4", sampP4, 32'd0);
        check("rst_instr", sampInstr, 32'd0);

        // Fill with decode stalled: queue saturates and fetch stops at 16.
        rst = 1'b0;
        loadExp(RESET_PC);
        tick();
        check("fill_req0", 32'(sampReq), 32'd1);
        check("fill_addr0", sampAddr, 32'd0);
        repeat (9) tick();
        check("full_count", sampCount, 32'd4);
        check("full_req", 32'(sampReq), 32'd0);
        check("full_addr", sampAddr, 32'd16);
        check("full_valid", 32'(sampValid), 32'd1);
        check("full_head_pc", sampPcd, 32'd0);
        check("full_head_instr", sampInstr, MAGIC);

        // Release decode: fetch resumes in the same cycle as the first pop.
        instr_ready = 1'b1;
        tick();
        check("drain_req", 32'(sampReq), 32'd1);
        check("drain_addr", sampAddr, 32'd16);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("drain_valid", 32'(sampValid), 32'd1);
        end
        check("steady_count", sampCount, 32'd3);

        // Redirect with three queued entries and one in flight.
        redirectTo(32'h0000_0100, 32'h0000_0100);
        repeat (3) tick();
        check("post_redir_valid", 32'(sampValid), 32'd1);

        // Redirect in the same cycle as a handshake; the head is flushed.
        redirectTo(32'h0000_0203, 32'h0000_0200);
        repeat (2) tick();

        // Address-space wrap.
        redirectTo(32'hFFFF_FFF8, 32'hFFFF_FFF8);
        tick();
        check("wrap_pcd_fc", sampPcd, 32'hFFFF_FFFC);
        check("wrap_p4_fc", sampP4, 32'h0000_0000);
        tick();
        check("wrap_pcd_0", sampPcd, 32'h0000_0000);
        repeat (2) tick();

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_count", 32'(q_count), 32'd0);
        check("arst_req", 32'(imem_req), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        loadExp(RESET_PC);
        tick();
        check("restart_req", 32'(sampReq), 32'd1);
        check("restart_addr", sampAddr, RESET_PC);
        check("restart_count", sampCount, 32'd0);
        lat = 0;
        while (!sampValid && lat < 10) begin
            tick();
            lat++;
        end
        check("restart_latency", 32'(lat), 32'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("restart_stream_valid", 32'(sampValid), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised successor of the single-register fetch front-end. It combines the PC register, the instruction-memory request and a DEPTH-entry instruction queue, so that fetch is decoupled from decode. Decode consumes {instr, PC, PC+4} through a valid/ready handshake. An execute-stage redirect (taken branch or jump) flushes the queue and discards any in-flight memory response. The block sits between the instruction memory and the decode pipeline register.

Parameters:
XLEN, 32, data/address width in bits
DEPTH, 4, queue entries; power of two, minimum 2
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
redirect_valid  input  1  redirect request from execute (PCSrcE equivalent)
redirect_pc  input  XLEN  redirect target (PCTargetE equivalent)
imem_req  output  1  fetch request this cycle
imem_addr  output  XLEN  fetch address (current PCF)
imem_rdata  input  XLEN  instruction word; valid exactly 1 cycle after imem_req
instr_valid  output  1  queue head is valid
instr_ready  input  1  decode accepts the head this cycle
instrD  output  XLEN  head instruction
PCD  output  XLEN  head PC
PCPlus4D  output  XLEN  head PC + 4
q_count  output  clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Reset (async, immediate):
  - PCF = RESET_PC.
  - Queue is empty; q_count = 0; instr_valid = 0.
  - instrD, PCD and PCPlus4D are 0.
  - The in-flight flag is cleared.
  - imem_req = 0 while rst is high.
- Pop: pop = instr_valid & instr_ready & ~redirect_valid.
- Fetch condition: imem_req = ~rst & ~redirect_valid & (q_count + inflight - pop < DEPTH).
  - inflight is a 1-bit registered flag.
  - imem_addr = PCF at all times.
  - When imem_req = 1: PCF <= PCF + 4, and inflight <= 1 with the request PC stored alongside it.
  - When imem_req = 0: inflight <= 0.
- Response: in the cycle after a request, if inflight = 1 and redirect_valid = 0, the block pushes {imem_rdata, stored PC, stored PC + 4} at the tail.
- Queue ordering and flow:
  - Entries leave in FIFO order.
  - Push and pop in the same cycle are legal; q_count is unchanged.
  - The fetch condition guarantees no push ever lands on a full queue.
  - Overflow is impossible; popping an empty queue is impossible, since pop requires instr_valid.
- Outputs: instrD, PCD and PCPlus4D come directly from the head entry (registered storage, no bypass). They hold their value while instr_valid = 1 and instr_ready = 0.
- Throughput: with instr_ready held at 1, the block delivers one instruction per cycle after the initial fill.
- Redirect in cycle t:
  - The queue is flushed (q_count = 0 at t+1).
  - Any response arriving in cycle t is discarded.
  - inflight <= 0.
  - PCF <= {redirect_pc[XLEN-1:2], 2'b00}.
  - No request is issued in cycle t.
  - A request at the new PC is issued in t+1.
  - instr_valid = 1 first at t+3 (redirect-to-decode latency of 3 cycles).
- Redirect together with instr_ready = 1: the flush wins and no pop is counted.
- Back-to-back redirects: the latest redirect_pc wins, and each redirect restarts the latency count.
- Arithmetic: PC + 4 is computed mod 2^XLEN; PCF wraps from all-ones-minus-3 to 0 silently.
- Pointers: read and write pointers are clog2(DEPTH) bits and wrap naturally.
- Reset asserted mid-stream: all state clears immediately, regardless of handshake. A memory response arriving after reset deasserts is ignored, because inflight = 0.

Test Plan:
1. Reset with RESET_PC=0, then release with instr_ready=1 and imem returning addr-derived words -> instr_valid first high 2 cycles after release; PCD sequence is 0,4,8,12 on consecutive cycles, with PCPlus4D = PCD+4.
2. instr_ready=0 for 10 cycles (DEPTH=4) -> q_count saturates at 4, imem_req drops to 0 and PCF holds at 16; on releasing ready, entries 0,4,8,12 drain in order with no gap before the next fetch.
3. Redirect to 0x100 while the queue holds 3 entries and a request is in flight -> the next cycle shows q_count=0 and instr_valid=0; the in-flight word is never presented; the first instr_valid is at t+3 with PCD=0x100.
4. Redirect to 0x203 in the same cycle as instr_valid=1 and instr_ready=1 -> the head is not consumed (flushed) and the next PCD delivered is 0x200.
5. Assert rst asynchronously mid-stream between clock edges -> instr_valid, q_count and imem_req go to 0 immediately; after release, fetch restarts at RESET_PC.
6. Set PCF near the top of the address space (redirect to 0xFFFFFFF8) and stream -> PCD sequence is 0xFFFFFFF8, 0xFFFFFFFC, 0x0, with PCPlus4D for 0xFFFFFFFC equal to 0x0.
